// File: rtl/reg_share_arbiter.sv
// reg_share_arbiter: round-robin arbiter that lends one shared register to
// four requesters. A grant lasts until the holder drops its request or has
// held the register for MAX_HOLD cycles. At least one idle cycle always
// separates two grants. N_REQ must be 4, because the owner index and the
// round-robin pointer are both 2 bits wide.
module reg_share_arbiter #(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       wr_en,
  input  logic [N_REQ*WIDTH-1:0] wdata,
  input  logic                   clr,
  output logic [N_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]       q,
  output logic [1:0]             q_owner,
  output logic                   busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [1:0]         idx_q, idx_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [3:0]         holdCnt_q, holdCnt_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [1:0]         owner_q, owner_d;

  logic [1:0]         pick;
  logic [1:0]         cand;
  logic               releaseNow;

  // Round-robin pick: walk offsets from high to low, so the requester closest above ptr wins.
  always_comb begin
    pick = ptr_q;
    cand = ptr_q;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      cand = ptr_q + 2'(off);
      if (req[cand]) begin
        pick = cand;
      end
    end
  end

  // Grant FSM: IDLE picks a winner; GRANT counts hold cycles and releases on drop or limit.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    idx_d      = idx_q;
    ptr_d      = ptr_q;
    holdCnt_d  = holdCnt_q;
    releaseNow = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (|req) begin
          state_d     = GRANT;
          gnt_d[pick] = 1'b1;
          idx_d       = pick;
          holdCnt_d   = 4'd1;
        end
      end
      GRANT: begin
        releaseNow = !req[idx_q] || (holdCnt_q == 4'(MAX_HOLD));
        if (releaseNow) begin
          state_d   = IDLE;
          gnt_d     = '0;
          ptr_d     = idx_q + 2'd1;
          holdCnt_d = 4'd0;
        end else begin
          holdCnt_d = holdCnt_q + 4'd1;
        end
      end
      default: begin
        state_d   = IDLE;
        gnt_d     = '0;
        holdCnt_d = 4'd0;
      end
    endcase
  end

  // Shared register: clear beats a write; only the current holder's strobe lands, even on its release edge.
  always_comb begin
    data_d  = data_q;
    owner_d = owner_q;
    if (clr) begin
      data_d = '0;
    end else if ((state_q == GRANT) && wr_en[idx_q]) begin
      data_d  = wdata[idx_q*WIDTH +: WIDTH];
      owner_d = idx_q;
    end
  end

  // State register with asynchronous active-low reset that aborts any grant in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      idx_q     <= 2'd0;
      ptr_q     <= 2'd0;
      holdCnt_q <= 4'd0;
      data_q    <= '0;
      owner_q   <= 2'd0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      holdCnt_q <= holdCnt_d;
      data_q    <= data_d;
      owner_q   <= owner_d;
    end
  end

  assign gnt     = gnt_q;
  assign busy    = |gnt_q;
  assign q       = data_q;
  assign q_owner = owner_q;

endmodule

// File: tb/tb_reg_share_arbiter.sv
// tb_reg_share_arbiter: drives two arbiters (MAX_HOLD=4 and MAX_HOLD=1) from
// one set of inputs and compares both against a behavioural model of grant
// order, hold limits and shared-register writes.
module tb_reg_share_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  wrEn;
  logic [31:0] wdata;
  logic        clr;

  logic [3:0]  gntA, gntB;
  logic [7:0]  qA, qB;
  logic [1:0]  ownerA, ownerB;
  logic        busyA, busyB;

  int total;
  int bad;
  bit checkOn;

  // Model state per instance: held requester (-1 = none), pointer, hold count, register, owner.
  int         mGrant [2];
  int         mPtr   [2];
  int         mHeld  [2];
  logic [7:0] mQ     [2];
  int         mOwner [2];

  reg_share_arbiter #(.N_REQ(4), .WIDTH(8), .MAX_HOLD(4)) dutA (
    .clk(clk), .rst(rst), .req(req), .wr_en(wrEn), .wdata(wdata), .clr(clr),
    .gnt(gntA), .q(qA), .q_owner(ownerA), .busy(busyA)
  );

  reg_share_arbiter #(.N_REQ(4), .WIDTH(8), .MAX_HOLD(1)) dutB (
    .clk(clk), .rst(rst), .req(req), .wr_en(wrEn), .wdata(wdata), .clr(clr),
    .gnt(gntB), .q(qB), .q_owner(ownerB), .busy(busyB)
  );

  // Free-running 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      mGrant[k] = -1;
      mPtr[k]   = 0;
      mHeld[k]  = 0;
      mQ[k]     = 8'h00;
      mOwner[k] = 0;
    end
  endtask

  task automatic modelStep(input int k, input int maxHold);
    int g;
    int idx;
    g = mGrant[k];
    if (clr) begin
      mQ[k] = 8'h00;
    end else if (g >= 0 && wrEn[g]) begin
      mQ[k]     = wdata[g*8 +: 8];
      mOwner[k] = g;
    end
    if (g < 0) begin
      for (int off = 0; off < 4; off++) begin
        idx = (mPtr[k] + off) % 4;
        if (mGrant[k] < 0 && req[idx]) begin
          mGrant[k] = idx;
          mHeld[k]  = 1;
        end
      end
    end else if (!req[g] || mHeld[k] == maxHold) begin
      mGrant[k] = -1;
      mPtr[k]   = (g + 1) % 4;
    end else begin
      mHeld[k]++;
    end
  endtask

  function automatic logic [31:0] expGnt(input int k);
    return (mGrant[k] < 0) ? 32'd0 : (32'd1 << mGrant[k]);
  endfunction

  // Advance the model on every rising edge, or clear it the moment reset asserts.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      modelReset();
    end else begin
      modelStep(0, 4);
      modelStep(1, 1);
    end
  end

  // On every falling edge, compare both instances against the model.
  always @(negedge clk) begin
    if (checkOn) begin
      checkOutput("gntA",   32'(gntA),   expGnt(0));
      checkOutput("busyA",  32'(busyA),  32'(mGrant[0] >= 0));
      checkOutput("qA",     32'(qA),     32'(mQ[0]));
      checkOutput("ownerA", 32'(ownerA), 32'(mOwner[0]));
      checkOutput("gntB",   32'(gntB),   expGnt(1));
      checkOutput("busyB",  32'(busyB),  32'(mGrant[1] >= 0));
      checkOutput("qB",     32'(qB),     32'(mQ[1]));
      checkOutput("ownerB", 32'(ownerB), 32'(mOwner[1]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] w, input logic [31:0] d, input logic c);
    req   = r;
    wrEn  = w;
    wdata = d;
    clr   = c;
  endtask

  task automatic applyReset();
    rst = 1'b0;
    applyStimulus(4'b0000, 4'b0000, 32'h0, 1'b0);
    tick();
    tick();
    rst = 1'b1;
  endtask

  int order [5] = '{0, 1, 2, 3, 0};
  logic [3:0] keepReq;

  // Directed scenarios with literal expectations, then a randomized soak.
  initial begin
    total   = 0;
    bad     = 0;
    checkOn = 0;
    rst     = 1'b1;
    applyStimulus(4'b0000, 4'b0000, 32'h0, 1'b0);
    #1;
    applyReset();
    checkOn = 1;

    checkOutput("reset_gnt",   32'(gntA),   32'h0);
    checkOutput("reset_busy",  32'(busyA),  32'h0);
    checkOutput("reset_q",     32'(qA),     32'h0);
    checkOutput("reset_owner", 32'(ownerA), 32'h0);

    // Basic grant to requester 2 with a write on the following edge.
    applyStimulus(4'b0100, 4'b0100, 32'h00A5_0000, 1'b0);
    tick();
    checkOutput("basic_gnt",  32'(gntA),  32'b0100);
    checkOutput("basic_busy", 32'(busyA), 32'h1);
    checkOutput("basic_q0",   32'(qA),    32'h00);
    tick();
    checkOutput("basic_q",     32'(qA),     32'hA5);
    checkOutput("basic_owner", 32'(ownerA), 32'h2);
    applyStimulus(4'b0000, 4'b0000, 32'h0, 1'b0);
    tick();
    checkOutput("basic_release", 32'(gntA), 32'h0);

    // Wrap-around: ptr is 3, requesters 0 and 1 ask.
    applyStimulus(4'b0011, 4'b0000, 32'h0, 1'b0);
    tick();
    checkOutput("wrap_gnt", 32'(gntA), 32'b0001);
    applyStimulus(4'b0000, 4'b0000, 32'h0, 1'b0);
    tick();
    applyStimulus(4'b0011, 4'b0000, 32'h0, 1'b0);
    tick();
    checkOutput("wrap_ptr1", 32'(gntA), 32'b0010);

    // Ignore a non-holder strobe, then clear beats the holder's write.
    applyStimulus(4'b0000, 4'b0000, 32'h0, 1'b0);
    tick();
    applyStimulus(4'b0010, 4'b0000, 32'h0, 1'b0);
    tick();
    checkOutput("ign_gnt", 32'(gntA), 32'b0010);
    applyStimulus(4'b0010, 4'b1000, 32'h3C00_0000, 1'b0);
    tick();
    checkOutput("ign_q",     32'(qA),     32'hA5);
    checkOutput("ign_owner", 32'(ownerA), 32'h2);
    applyStimulus(4'b0010, 4'b0010, 32'h0000_FF00, 1'b1);
    tick();
    checkOutput("clr_q",     32'(qA),     32'h00);
    checkOutput("clr_owner", 32'(ownerA), 32'h2);

    // Early release with a same-edge write, then ptr=1 sends 4'b1001 to requester 3.
    applyStimulus(4'b0000, 4'b0000, 32'h0, 1'b0);
    tick();
    applyStimulus(4'b0001, 4'b0000, 32'h0, 1'b0);
    tick();
    checkOutput("early_gnt", 32'(gntA), 32'b0001);
    tick();
    applyStimulus(4'b0000, 4'b0001, 32'h0000_0011, 1'b0);
    tick();
    checkOutput("early_q",     32'(qA),     32'h11);
    checkOutput("early_owner", 32'(ownerA), 32'h0);
    checkOutput("early_rel",   32'(gntA),   32'h0);
    applyStimulus(4'b1001, 4'b0000, 32'h0, 1'b0);
    tick();
    checkOutput("early_next", 32'(gntA), 32'b1000);
    applyStimulus(4'b0000, 4'b0000, 32'h0, 1'b0);
    tick();

    // Reset asserted between edges mid-grant.
    applyReset();
    applyStimulus(4'b0100, 4'b0100, 32'h005A_0000, 1'b0);
    tick();
    tick();
    checkOutput("rmid_q", 32'(qA), 32'h5A);
    #3;
    rst = 1'b0;
    #1;
    checkOutput("rmid_gnt",   32'(gntA),   32'h0);
    checkOutput("rmid_busy",  32'(busyA),  32'h0);
    checkOutput("rmid_q0",    32'(qA),     32'h0);
    checkOutput("rmid_owner", 32'(ownerA), 32'h0);
    applyStimulus(4'b1111, 4'b0000, 32'h0, 1'b0);
    #2;
    rst = 1'b1;
    tick();
    checkOutput("rmid_after", 32'(gntA), 32'b0001);

    // Round-robin with every request held; instance B shows one-cycle grants.
    applyReset();
    applyStimulus(4'b1111, 4'b0000, 32'h0, 1'b0);
    for (int k = 1; k <= 25; k++) begin
      tick();
      checkOutput("rr_A", 32'(gntA),
                  (((k - 1) % 5) < 4) ? (32'd1 << order[(k - 1) / 5]) : 32'd0);
      checkOutput("rr_B", 32'(gntB),
                  ((k % 2) == 1) ? (32'd1 << (((k - 1) / 2) % 4)) : 32'd0);
    end

    // Randomized soak: sticky requests, random strobes/data, occasional clear and reset.
    keepReq = 4'b1111;
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        keepReq = 4'($urandom_range(0, 15));
      end
      applyStimulus(keepReq, 4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b0;
        #2;
        rst = 1'b1;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
